// File: rtl/quad_packet_arbiter.sv
// quad_packet_arbiter
// Round-robin packet arbiter merging the four per-channel packet buffers into
// the single Ethernet sender on the upper GMII clock. One buffer is granted at
// a time, its byte stream is forwarded through one register stage, and a fixed
// inter-packet gap is inserted before the next arbitration.
// Optional feature: define ARB_TIMEOUT_EN to abandon a grant whose buffer does
// not start its packet within TIMEOUT_CYCLES cycles.
module quad_packet_arbiter #(
  parameter int GAP_CYCLES     = 12,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ch0_data,
  input  logic       ch0_datavalid,
  input  logic       ch0_request,
  output logic       ch0_grant,
  input  logic [7:0] ch1_data,
  input  logic       ch1_datavalid,
  input  logic       ch1_request,
  output logic       ch1_grant,
  input  logic [7:0] ch2_data,
  input  logic       ch2_datavalid,
  input  logic       ch2_request,
  output logic       ch2_grant,
  input  logic [7:0] ch3_data,
  input  logic       ch3_datavalid,
  input  logic       ch3_request,
  output logic       ch3_grant,
  input  logic       sender_ready,
  output logic [7:0] send_data,
  output logic       send_datav,
  output logic       timeout_pulse,
  output logic [4:0] arbiter_state
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  // One-hot encoding so the state register can be exported directly.
  typedef enum logic [4:0] {
    ST_IDLE     = 5'b00001,
    ST_WAIT_RDY = 5'b00010,
    ST_GRANT    = 5'b00100,
    ST_XFER     = 5'b01000,
    ST_GAP      = 5'b10000
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [1:0]    sel;
  logic [1:0]    sel_next;
  logic [1:0]    last;
  logic [1:0]    last_next;
  logic [GW-1:0] gap_cnt;
  logic [GW-1:0] gap_next;
  logic [3:0]    grant;
  logic [3:0]    grant_next;
  logic [7:0]    send_data_next;
  logic          send_datav_next;
  logic          timeout_hit;

  logic [3:0]    req;
  logic [3:0]    dv;
  logic [7:0]    ch_data [4];
  logic [7:0]    chsel_data;
  logic          chsel_datavalid;
  logic          chsel_request;

  if (GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("quad_packet_arbiter: GAP_CYCLES and TIMEOUT_CYCLES must be at least 1");
  end

  assign req        = {ch3_request, ch2_request, ch1_request, ch0_request};
  assign dv         = {ch3_datavalid, ch2_datavalid, ch1_datavalid, ch0_datavalid};
  assign ch_data[0] = ch0_data;
  assign ch_data[1] = ch1_data;
  assign ch_data[2] = ch2_data;
  assign ch_data[3] = ch3_data;

  // First requesting channel after 'from', wrapping so 'from' itself is last.
  function automatic logic [1:0] next_channel(input logic [1:0] from,
                                              input logic [3:0] r);
    logic [1:0] cand;
    logic       found;
    next_channel = from;
    found        = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = from + 2'(k);
      if (!found && r[cand]) begin
        next_channel = cand;
        found        = 1'b1;
      end
    end
  endfunction

  // Route the selected buffer's signals; other channels are never looked at.
  always_comb begin
    chsel_data      = ch_data[sel];
    chsel_datavalid = dv[sel];
    chsel_request   = req[sel];
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tout_cnt;

  // Count cycles spent in GRANT without a first valid byte; cleared elsewhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tout_cnt <= '0;
    else if (state != ST_GRANT)
      tout_cnt <= '0;
    else if (!chsel_datavalid && tout_cnt != TIMEOUT_LAST)
      tout_cnt <= tout_cnt + 1'b1;
  end

  assign timeout_hit = (state == ST_GRANT) && !chsel_datavalid &&
                       (tout_cnt == TIMEOUT_LAST);

  // Single-cycle pulse coinciding with the grant being withdrawn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      timeout_pulse <= 1'b0;
    else
      timeout_pulse <= timeout_hit;
  end
`else
  assign timeout_hit   = 1'b0;
  assign timeout_pulse = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (|req)
          state_next = ST_WAIT_RDY;
      end
      ST_WAIT_RDY: begin
        if (!chsel_request)
          state_next = ST_IDLE;
        else if (sender_ready)
          state_next = ST_GRANT;
      end
      ST_GRANT: begin
        if (chsel_datavalid)
          state_next = ST_XFER;
        else if (timeout_hit)
          state_next = ST_GAP;
      end
      ST_XFER: begin
        if (!chsel_datavalid)
          state_next = ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt == '0)
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output and datapath next values: selection, priority, gap, grant, forwarding.
  always_comb begin
    sel_next        = sel;
    last_next       = last;
    gap_next        = gap_cnt;
    grant_next      = grant;
    send_data_next  = send_data;
    send_datav_next = 1'b0;
    unique case (state)
      ST_IDLE: begin
        grant_next = 4'b0000;
        if (|req)
          sel_next = next_channel(last, req);
      end
      ST_WAIT_RDY: begin
        grant_next = 4'b0000;
        if (chsel_request && sender_ready)
          grant_next = 4'b0001 << sel;
      end
      ST_GRANT: begin
        send_data_next  = chsel_data;
        send_datav_next = chsel_datavalid;
        if (!chsel_datavalid && timeout_hit) begin
          grant_next = 4'b0000;
          last_next  = sel;
          gap_next   = GAP_LOAD;
        end
      end
      ST_XFER: begin
        send_data_next  = chsel_data;
        send_datav_next = chsel_datavalid;
        if (!chsel_datavalid) begin
          grant_next = 4'b0000;
          last_next  = sel;
          gap_next   = GAP_LOAD;
        end
      end
      ST_GAP: begin
        grant_next = 4'b0000;
        if (gap_cnt != '0)
          gap_next = gap_cnt - 1'b1;
      end
      default: grant_next = 4'b0000;
    endcase
  end

  // Datapath registers; last starts at 3 so channel 0 wins the first arbitration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel        <= 2'd0;
      last       <= 2'd3;
      gap_cnt    <= '0;
      grant      <= 4'b0000;
      send_data  <= 8'h00;
      send_datav <= 1'b0;
    end else begin
      sel        <= sel_next;
      last       <= last_next;
      gap_cnt    <= gap_next;
      grant      <= grant_next;
      send_data  <= send_data_next;
      send_datav <= send_datav_next;
    end
  end

  assign ch0_grant     = grant[0];
  assign ch1_grant     = grant[1];
  assign ch2_grant     = grant[2];
  assign ch3_grant     = grant[3];
  assign arbiter_state = state;

endmodule

// File: tb/tb_quad_packet_arbiter.sv
// Testbench for quad_packet_arbiter: scoreboard of expected grant order (from a
// round-robin model over pending packet counts) and expected forwarded bytes
// with their arrival cycles, checked by an independent monitor.
module tb_quad_packet_arbiter;

  localparam int GAP  = 12;
  localparam int TOUT = 8;
  localparam logic [4:0] S_IDLE = 5'b00001;
  localparam logic [4:0] S_WAIT = 5'b00010;
  localparam logic [4:0] S_GAP  = 5'b10000;

  typedef struct {
    logic [7:0] value;
    int         due;
  } byte_exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data [4];
  logic [3:0] req;
  logic [3:0] dv;
  logic       sender_ready;
  logic [3:0] grant;
  logic [7:0] send_data;
  logic       send_datav;
  logic       timeout_pulse;
  logic [4:0] arbiter_state;

  byte_exp_t  exp_bytes[$];
  int         exp_grants[$];
  byte_exp_t  mon_e;
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic [3:0] prev_grant = 4'b0000;
  int         last_fall = -1;
  int         pend[4];
  int         m_last;
  bit         rand_ready = 1'b0;

  quad_packet_arbiter #(
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ch0_data      (data[0]),
    .ch0_datavalid (dv[0]),
    .ch0_request   (req[0]),
    .ch0_grant     (grant[0]),
    .ch1_data      (data[1]),
    .ch1_datavalid (dv[1]),
    .ch1_request   (req[1]),
    .ch1_grant     (grant[1]),
    .ch2_data      (data[2]),
    .ch2_datavalid (dv[2]),
    .ch2_request   (req[2]),
    .ch2_grant     (grant[2]),
    .ch3_data      (data[3]),
    .ch3_datavalid (dv[3]),
    .ch3_request   (req[3]),
    .ch3_grant     (grant[3]),
    .sender_ready  (sender_ready),
    .send_data     (send_data),
    .send_datav    (send_datav),
    .timeout_pulse (timeout_pulse),
    .arbiter_state (arbiter_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic int ch_of(input logic [3:0] g);
    ch_of = -1;
    for (int k = 3; k >= 0; k--)
      if (g[k]) ch_of = k;
  endfunction

  // Random sender_ready while enabled.
  initial begin
    forever begin
      @(negedge clk);
      if (rand_ready) sender_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: grant order, grant exclusivity, grant spacing, forwarded bytes.
  always @(negedge clk) begin
    if (rst) begin
      prev_grant = 4'b0000;
      last_fall  = -1;
    end else begin
      check_output("grant_onehot", int'($onehot0(grant)), 1);
`ifndef ARB_TIMEOUT_EN
      check_output("timeout_tied_low", int'(timeout_pulse), 0);
`endif
      if (grant != 4'b0000 && prev_grant == 4'b0000) begin
        if (exp_grants.size() == 0)
          check_output("grant_unexpected", ch_of(grant), -1);
        else
          check_output("grant_order", ch_of(grant), exp_grants.pop_front());
        if (last_fall >= 0)
          check_output("grant_spacing_ok", int'(cyc - last_fall >= GAP + 2), 1);
      end
      if (grant == 4'b0000 && prev_grant != 4'b0000)
        last_fall = cyc;
      if (send_datav) begin
        if (exp_bytes.size() == 0) begin
          check_output("byte_unexpected", int'(send_data), -1);
        end else begin
          mon_e = exp_bytes.pop_front();
          check_output("send_data", int'(send_data), int'(mon_e.value));
          check_output("byte_cycle", cyc, mon_e.due);
        end
      end
      prev_grant = grant;
    end
  end

  task automatic wait_grant(input int bound, output int got);
    int n;
    n   = 0;
    got = -1;
    while (grant == 4'b0000 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (grant != 4'b0000) got = ch_of(grant);
    else check_output("grant_wait_expired", 0, 1);
  endtask

  task automatic wait_state(input logic [4:0] target, input int bound);
    int n;
    n = 0;
    while (arbiter_state != target && n < bound) begin
      @(negedge clk);
      n++;
    end
    check_output("reach_state", int'(arbiter_state), int'(target));
  endtask

  // Stream one packet on an already-granted channel, with noise on the others.
  task automatic apply_stimulus(input int ch, input int len, input int pre, input bit ramp);
    logic [7:0] b;
    repeat (pre) @(negedge clk);
    for (int i = 0; i < len; i++) begin
      b = ramp ? 8'(i) : 8'($urandom);
      data[ch] = b;
      dv[ch]   = 1'b1;
      exp_bytes.push_back('{value: b, due: cyc + 1});
      for (int k = 0; k < 4; k++) begin
        if (k != ch) begin
          dv[k]   = 1'($urandom_range(0, 1));
          data[k] = 8'($urandom);
        end
      end
      @(negedge clk);
    end
    check_output("grant_hold", int'(grant[ch]), 1);
    dv = 4'b0000;
    @(negedge clk);
    check_output("grant_fall", int'(grant[ch]), 0);
  endtask

  // Reference model: serve pending packets by rotation from the last served channel.
  task automatic run_round();
    int tmp[4];
    int total;
    int got;
    int ch;
    total = 0;
    ch    = 0;
    for (int k = 0; k < 4; k++) begin
      tmp[k] = pend[k];
      total += pend[k];
    end
    for (int p = 0; p < total; p++) begin
      for (int s = 1; s <= 4; s++) begin
        ch = (m_last + s) % 4;
        if (tmp[ch] > 0) break;
      end
      tmp[ch]--;
      exp_grants.push_back(ch);
      m_last = ch;
    end
    for (int k = 0; k < 4; k++) req[k] = (pend[k] > 0);
    rand_ready = 1'b1;
    for (int p = 0; p < total; p++) begin
      wait_grant(300, got);
      if (got < 0) break;
      if (pend[got] > 0) pend[got]--;
      req[got] = (pend[got] > 0);
      apply_stimulus(got, $urandom_range(1, 20), $urandom_range(0, 3), 1'b0);
    end
    rand_ready   = 1'b0;
    sender_ready = 1'b1;
    req          = 4'b0000;
    for (int k = 0; k < 4; k++) pend[k] = 0;
    wait_state(S_IDLE, 40);
  endtask

  initial begin
    int got;
    int t0;
    int n;
    bit seen;
    rst          = 1'b1;
    req          = 4'b0000;
    dv           = 4'b0000;
    sender_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      data[k] = 8'h00;
      pend[k] = 0;
    end
    m_last = 3;
    repeat (3) @(negedge clk);
    check_output("reset_state", int'(arbiter_state), int'(S_IDLE));
    check_output("reset_grants", int'(grant), 0);
    check_output("reset_send_data", int'(send_data), 0);
    check_output("reset_send_datav", int'(send_datav), 0);
    check_output("reset_timeout_pulse", int'(timeout_pulse), 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] single channel ramp packet on ch2");
    exp_grants.push_back(2);
    req[2]       = 1'b1;
    sender_ready = 1'b1;
    t0           = cyc;
    wait_grant(10, got);
    check_output("ch2_grant", got, 2);
    check_output("req_to_grant_cycles", cyc - t0, 2);
    req[2] = 1'b0;
    m_last = 2;
    apply_stimulus(2, 64, 0, 1'b1);
    n = 0;
    while (arbiter_state == S_GAP && n < 40) begin
      n++;
      @(negedge clk);
    end
    check_output("gap_cycles", n, GAP);
    check_output("after_gap_state", int'(arbiter_state), int'(S_IDLE));

    $display("[TB] sender_ready held low with ch1 requesting");
    exp_grants.push_back(1);
    req[1]       = 1'b1;
    sender_ready = 1'b0;
    seen         = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (grant != 4'b0000) seen = 1'b1;
    end
    check_output("no_grant_without_ready", int'(seen), 0);
    check_output("held_in_wait_rdy", int'(arbiter_state), int'(S_WAIT));
    sender_ready = 1'b1;
    @(negedge clk);
    check_output("grant_after_ready", int'(grant[1]), 1);
    req[1] = 1'b0;
    m_last = 1;
    apply_stimulus(1, 16, 0, 1'b0);
    wait_state(S_IDLE, 40);

    $display("[TB] reset in the middle of a ch0 packet");
    exp_grants.push_back(0);
    req[0] = 1'b1;
    wait_grant(10, got);
    check_output("ch0_grant", got, 0);
    req[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      data[0] = 8'(i);
      dv[0]   = 1'b1;
      exp_bytes.push_back('{value: 8'(i), due: cyc + 1});
      @(negedge clk);
    end
    data[0] = 8'd10;
    #2;
    rst = 1'b1;
    exp_bytes.delete();
    exp_grants.delete();
    dv     = 4'b0000;
    req    = 4'b0000;
    m_last = 3;
    #1;
    check_output("async_reset_grants", int'(grant), 0);
    check_output("async_reset_datav", int'(send_datav), 0);
    check_output("async_reset_state", int'(arbiter_state), int'(S_IDLE));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    $display("[TB] all four channels requesting");
    pend[0] = 2;
    pend[1] = 1;
    pend[2] = 1;
    pend[3] = 1;
    run_round();

    $display("[TB] randomized rounds");
    repeat (6) begin
      for (int k = 0; k < 4; k++) pend[k] = $urandom_range(0, 2);
      if (pend[0] + pend[1] + pend[2] + pend[3] == 0) pend[$urandom_range(0, 3)] = 1;
      run_round();
    end

`ifdef ARB_TIMEOUT_EN
    $display("[TB] grant timeout on ch1");
    @(negedge clk);
    #2;
    rst = 1'b1;
    exp_bytes.delete();
    exp_grants.delete();
    m_last = 3;
    @(negedge clk);
    rst = 1'b0;
    exp_grants.push_back(1);
    exp_grants.push_back(2);
    req[1]       = 1'b1;
    req[2]       = 1'b1;
    sender_ready = 1'b1;
    wait_grant(10, got);
    check_output("timeout_ch1_grant", got, 1);
    t0 = cyc;
    n  = 0;
    while (!timeout_pulse && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_output("timeout_delay", cyc - t0, TOUT);
    check_output("timeout_grant_drop", int'(grant), 0);
    req[1] = 1'b0;
    @(negedge clk);
    check_output("timeout_pulse_width", int'(timeout_pulse), 0);
    wait_grant(40, got);
    check_output("after_timeout_grant", got, 2);
    req[2] = 1'b0;
    apply_stimulus(2, 4, 0, 1'b0);
    wait_state(S_IDLE, 40);
`endif

    repeat (3) @(negedge clk);
    check_output("bytes_outstanding", exp_bytes.size(), 0);
    check_output("grants_outstanding", exp_grants.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] time limit reached");
  end

endmodule

// File: doc/quad_packet_arbiter.md
# quad_packet_arbiter

Packet-level round-robin arbiter that merges the four per-channel packet buffers into the single Ethernet sender on the upper GMII clock. It sits directly downstream of the per-channel packet buffers and upstream of the Ethernet sender. It grants one buffer at a time, forwards that buffer's byte stream with one register stage, and inserts a fixed inter-packet gap before rotating priority.

## Interface
Parameters:
- GAP_CYCLES, 12: idle cycles between end of one packet and the next arbitration.
- TIMEOUT_CYCLES, 1024: cycles a granted channel may take to start its packet (only with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  upper GMII clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- chN_data (N=0..3)  in  8  byte from buffer N.
- chN_datavalid (N=0..3)  in  1  byte valid from buffer N.
- chN_request (N=0..3)  in  1  buffer N holds at least one complete packet.
- chN_grant (N=0..3)  out  1  buffer N may stream its packet; registered.
- sender_ready  in  1  sender idle and able to accept a new packet.
- send_data  out  8  forwarded byte; registered.
- send_datav  out  1  forwarded byte valid; registered.
- timeout_pulse  out  1  one-cycle pulse on grant timeout (0 without ARB_TIMEOUT_EN).
- arbiter_state  out  5  one-hot state: bit0 IDLE, bit1 WAIT_RDY, bit2 GRANT, bit3 XFER, bit4 GAP.

## Operation
- IDLE: if any chN_request is high, select the first requesting channel in order last+1, last+2, last+3, last (mod 4). Latch the selection into sel and go to WAIT_RDY.
- WAIT_RDY:
  - If chsel_request is low, return to IDLE (no grant, last unchanged).
  - Otherwise, when sender_ready is high, set chsel_grant and go to GRANT.
- GRANT: hold the grant. On the first chsel_datavalid high, go to XFER.
- XFER: hold the grant. On the first cycle chsel_datavalid is low, clear the grant, load the gap counter with GAP_CYCLES-1, set last=sel and go to GAP. A single low valid cycle always ends the packet.
- GAP: decrement the counter; at 0, go to IDLE.
- Forwarding, every cycle:
  - send_data <= chsel_data and send_datav <= chsel_datavalid while in GRANT or XFER.
  - Otherwise send_datav <= 0 and send_data holds its value.
- Datavalid from non-selected channels is ignored. At most one chN_grant is high at any time.
- sender_ready is sampled only in WAIT_RDY. Its deassertion during XFER is ignored.
- Reset values: all grants 0, send_data 0x00, send_datav 0, timeout_pulse 0, arbiter_state 5'b00001, last=3 (so ch0 has first priority), gap and timeout counters 0.
- Reset asserted mid-packet: all outputs return to reset values immediately and asynchronously. The partial packet is truncated and the sender sees valid fall.

## Timing
- Request to grant: IDLE→WAIT_RDY takes 1 cycle. The grant is visible 1 cycle after sender_ready is sampled high in WAIT_RDY, so 2 cycles minimum from request.
- Data latency: send_data/send_datav follow chsel_data/chsel_datavalid by exactly 1 cycle.
- End of packet: the grant falls on the cycle after datavalid falls.
- Gap: exactly GAP_CYCLES cycles in GAP, then IDLE. The next grant is no earlier than GAP_CYCLES+2 cycles after the grant falls.
- Simultaneous requests: resolved by the rotation only. The same channel is never served twice in a row while another channel requests.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A counter runs in GRANT. If TIMEOUT_CYCLES elapse with no chsel_datavalid, the block clears the grant, pulses timeout_pulse for 1 cycle, sets last=sel and goes to GAP.
- ARB_TIMEOUT_EN undefined:
  - GRANT waits indefinitely.
  - timeout_pulse is tied to 0 and no counter is built.

## Test plan
- Single channel: ch2_request=1, sender_ready=1, ch2 sends 64 bytes 0x00..0x3F → ch2_grant rises 2 cycles after request. send_data reproduces 0x00..0x3F delayed 1 cycle with send_datav high for 64 cycles. ch2_grant falls 1 cycle after valid falls. arbiter_state shows GAP for 12 cycles.
- All four request continuously with 16-byte packets → grant order ch0, ch1, ch2, ch3, ch0. Never two grants high at once.
- sender_ready held 0 for 50 cycles with ch1 requesting → block stays in WAIT_RDY with no grant. Grant appears 1 cycle after ready rises.
- ch3_datavalid pulsed on unselected ch3 during a ch0 transfer → send_data carries only ch0 bytes.
- Reset asserted at byte 10 of a 64-byte packet → send_datav and all grants go to 0 immediately. After release, ch0 wins when all channels request.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, ch1 granted but never valid → timeout_pulse high for 1 cycle, 8 cycles after the grant. The grant drops and the next grant goes to ch2 if it requests.
